// File: rtl/vga_text_bitgen.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_bitgen
// Brief    : 80x60 text-mode pixel generator with blink attribute and cursor.
// Revision : 1.0 - initial release
// ============================================================================
module vga_text_bitgen #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 60,
    parameter logic [7:0] FG           = 8'hFF,
    parameter logic [7:0] BG           = 8'h00,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic        hSync,
    input  logic        vSync,
    output logic [12:0] mapAddr,
    input  logic [7:0]  mapData,
    output logic [9:0]  glyphAddr,
    input  logic [7:0]  glyphData,
    input  logic        cursorEn,
    input  logic [6:0]  cursorCol,
    input  logic [5:0]  cursorRow,
    output logic [7:0]  rgb,
    output logic        hSyncOut,
    output logic        vSyncOut,
    output logic        brightOut
);

    localparam int             c_FCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_FCW-1:0] c_FRAME_LAST = c_FCW'(BLINK_FRAMES - 1);
    localparam logic [6:0]     c_COLS       = 7'(COLS);
    localparam logic [6:0]     c_ROWS       = 7'(ROWS);

    logic [6:0]  w_col;
    logic [6:0]  w_row;
    logic [12:0] w_tile_base;
    logic [12:0] w_addr;
    logic        w_in_range;
    logic        w_pix;
    logic        w_vs_fall;

    logic [12:0] r_mapAddr;
    logic [9:0]  r_glyphAddr;
    logic [2:0]  r_xoff1, r_xoff2, r_xoff3, r_xoff4;
    logic [2:0]  r_vrow1, r_vrow2;
    logic [6:0]  r_col1, r_col2;
    logic [6:0]  r_row1, r_row2;
    logic        r_blink3, r_blink4;
    logic        r_cursor3, r_cursor4;
    logic [3:0]  r_hs_dly;
    logic [3:0]  r_vs_dly;
    logic [3:0]  r_br_dly;

    logic              r_vs_prev;
    logic [c_FCW-1:0]  r_frameCnt;
    logic              r_blinkPhase;

    assign w_col      = hCount[9:3];
    assign w_row      = vCount[9:3];
    assign w_in_range = (w_col < c_COLS) && (w_row < c_ROWS);

    generate
        if (COLS == 80) begin : g_mul80
            assign w_tile_base = ({6'b0, w_row} << 6) + ({6'b0, w_row} << 4);
        end else begin : g_mulgen
            assign w_tile_base = 13'(int'(w_row) * COLS);
        end
    endgenerate

    assign w_addr = w_tile_base + {6'b0, w_col};

    // Fetch pipeline: map address, map data -> glyph address, glyph data -> pixel.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_mapAddr   <= '0;
            r_glyphAddr <= '0;
            r_xoff1     <= '0;
            r_xoff2     <= '0;
            r_xoff3     <= '0;
            r_xoff4     <= '0;
            r_vrow1     <= '0;
            r_vrow2     <= '0;
            r_col1      <= '0;
            r_col2      <= '0;
            r_row1      <= '0;
            r_row2      <= '0;
            r_blink3    <= 1'b0;
            r_blink4    <= 1'b0;
            r_cursor3   <= 1'b0;
            r_cursor4   <= 1'b0;
            r_hs_dly    <= '1;
            r_vs_dly    <= '1;
            r_br_dly    <= '0;
        end else begin
            if (bright && w_in_range) begin
                r_mapAddr <= w_addr;
            end
            r_xoff1     <= hCount[2:0];
            r_vrow1     <= vCount[2:0];
            r_col1      <= w_col;
            r_row1      <= w_row;

            r_xoff2     <= r_xoff1;
            r_vrow2     <= r_vrow1;
            r_col2      <= r_col1;
            r_row2      <= r_row1;

            r_glyphAddr <= {mapData[6:0], r_vrow2};
            r_blink3    <= mapData[7];
            r_cursor3   <= cursorEn && (r_col2 == cursorCol) && (r_row2 == {1'b0, cursorRow});
            r_xoff3     <= r_xoff2;

            r_blink4    <= r_blink3;
            r_cursor4   <= r_cursor3;
            r_xoff4     <= r_xoff3;

            r_hs_dly    <= {r_hs_dly[2:0], hSync};
            r_vs_dly    <= {r_vs_dly[2:0], vSync};
            r_br_dly    <= {r_br_dly[2:0], bright};
        end
    end

    // Frame counter advances on each vSync falling edge; wrap toggles the blink phase.
    assign w_vs_fall = r_vs_prev && !vSync;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_vs_prev    <= 1'b1;
            r_frameCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else begin
            r_vs_prev <= vSync;
            if (w_vs_fall) begin
                if (r_frameCnt == c_FRAME_LAST) begin
                    r_frameCnt   <= '0;
                    r_blinkPhase <= ~r_blinkPhase;
                end else begin
                    r_frameCnt <= r_frameCnt + c_FCW'(1);
                end
            end
        end
    end

    // Glyph data arrives in the same cycle as the stage-4 controls, so colour is resolved here.
    always_comb begin
        w_pix = glyphData[3'd7 - r_xoff4];
        if (r_blink4 && r_blinkPhase) begin
            w_pix = 1'b0;
        end
        if (r_cursor4 && !r_blinkPhase) begin
            w_pix = ~w_pix;
        end
    end

    assign rgb       = r_br_dly[3] ? (w_pix ? FG : BG) : 8'h00;
    assign mapAddr   = r_mapAddr;
    assign glyphAddr = r_glyphAddr;
    assign hSyncOut  = r_hs_dly[3];
    assign vSyncOut  = r_vs_dly[3];
    assign brightOut = r_br_dly[3];

endmodule
`default_nettype wire

// File: tb/tb_vga_text_bitgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_text_bitgen
// Brief    : Directed and random checks of the text pixel generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_text_bitgen;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [9:0]  hCount = '0;
    logic [9:0]  vCount = '0;
    logic        bright = 1'b0;
    logic        hSync = 1'b1;
    logic        vSync = 1'b1;
    logic [12:0] mapAddr;
    logic [7:0]  mapData = '0;
    logic [9:0]  glyphAddr;
    logic [7:0]  glyphData = '0;
    logic        cursorEn = 1'b0;
    logic [6:0]  cursorCol = 7'd10;
    logic [5:0]  cursorRow = 6'd4;
    logic [7:0]  rgb;
    logic        hSyncOut;
    logic        vSyncOut;
    logic        brightOut;

    vga_text_bitgen dut (
        .clock     (clock),
        .clear     (clear),
        .hCount    (hCount),
        .vCount    (vCount),
        .bright    (bright),
        .hSync     (hSync),
        .vSync     (vSync),
        .mapAddr   (mapAddr),
        .mapData   (mapData),
        .glyphAddr (glyphAddr),
        .glyphData (glyphData),
        .cursorEn  (cursorEn),
        .cursorCol (cursorCol),
        .cursorRow (cursorRow),
        .rgb       (rgb),
        .hSyncOut  (hSyncOut),
        .vSyncOut  (vSyncOut),
        .brightOut (brightOut)
    );

    always #20 clock = ~clock;

    logic [7:0] mapMem  [0:4799];
    logic [7:0] fontMem [0:1023];

    always @(posedge clock) begin
        mapData   <= mapMem[mapAddr];
        glyphData <= fontMem[glyphAddr];
    end

    typedef struct {
        logic        br;
        logic        hs;
        logic        vs;
        logic        raw;
        logic        battr;
        logic        cur;
        logic [12:0] addr;
        logic [9:0]  ga;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          falls    = 0;
    logic        prev_vs  = 1'b1;
    logic [12:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one pixel's inputs and record what the screen should show for it.
    task automatic drive(input logic br, input int h, input int v, input logic hs, input logic vs);
        exp_t e;
        int   col, row, ch, g;
        hCount = 10'(h);
        vCount = 10'(v);
        bright = br;
        hSync  = hs;
        vSync  = vs;
        if (prev_vs && !vs) falls++;
        prev_vs = vs;
        col = h / 8;
        row = v / 8;
        if (br && col < 80 && row < 60) pend_addr = 13'(row * 80 + col);
        e.br = br;
        e.hs = hs;
        e.vs = vs;
        e.addr = pend_addr;
        e.ga = {mapMem[pend_addr][6:0], 3'(v % 8)};
        e.raw = 1'b0;
        e.battr = 1'b0;
        e.cur = 1'b0;
        if (br) begin
            ch = int'(mapMem[row * 80 + col]);
            g  = int'(fontMem[(ch % 128) * 8 + (v % 8)]);
            e.raw   = ((g >> (7 - (h % 8))) & 1) == 1;
            e.battr = ch >= 128;
            e.cur   = cursorEn && (col == int'(cursorCol)) && (row == int'(cursorRow));
        end
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        int   phase;
        logic p;
        @(posedge clock);
        #1;
        if (q.size() > 0) chk("mapAddr", 16'(mapAddr), 16'(q[q.size()-1].addr));
        if (q.size() >= 3) chk("glyphAddr", 16'(glyphAddr), 16'(q[q.size()-3].ga));
        if (q.size() == 4) begin
            e = q.pop_front();
            phase = (falls / 30) % 2;
            p = e.raw;
            if (e.battr && phase == 1) p = 1'b0;
            if (e.cur && phase == 0) p = ~p;
            chk("rgb", 16'(rgb), (e.br && p) ? 16'h00FF : 16'h0000);
            chk("hSyncOut", 16'(hSyncOut), 16'(e.hs));
            chk("vSyncOut", 16'(vSyncOut), 16'(e.vs));
            chk("brightOut", 16'(brightOut), 16'(e.br));
        end
    endtask

    task automatic pix(input logic br, input int h, input int v, input logic hs, input logic vs);
        drive(br, h, v, hs, vs);
        step();
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) pix(1'b0, 700, 500, 1'b1, 1'b1);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pix(1'b0, 700, 490, 1'b1, 1'b0);
            pix(1'b0, 700, 491, 1'b1, 1'b1);
        end
    endtask

    // Asynchronous reset taken between clock edges, outputs checked before the next edge.
    task automatic do_reset();
        #2;
        clear = 1'b0;
        #1;
        chk("rst_rgb", 16'(rgb), 16'h0000);
        chk("rst_hSyncOut", 16'(hSyncOut), 16'h0001);
        chk("rst_vSyncOut", 16'(vSyncOut), 16'h0001);
        chk("rst_brightOut", 16'(brightOut), 16'h0000);
        chk("rst_mapAddr", 16'(mapAddr), 16'h0000);
        chk("rst_glyphAddr", 16'(glyphAddr), 16'h0000);
        q.delete();
        falls = 0;
        prev_vs = 1'b1;
        pend_addr = '0;
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4800; i++) mapMem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) fontMem[i] = 8'($urandom);
        mapMem[82]  = 8'h41;
        mapMem[245] = 8'hFF;
        mapMem[330] = 8'h00;
        for (int r = 0; r < 8; r++) begin
            fontMem[8'h41 * 8 + r] = 8'h80;
            fontMem[8'h7F * 8 + r] = 8'hFF;
            fontMem[r]             = 8'h00;
        end

        repeat (2) @(posedge clock);
        #1;
        do_reset();

        pix(1'b1, 17, 9, 1'b1, 1'b1);
        chk("addr_82", 16'(mapAddr), 16'd82);
        pix(1'b1, 639, 479, 1'b1, 1'b1);
        chk("addr_4799", 16'(mapAddr), 16'd4799);
        flush();

        for (int x = 16; x < 24; x++) pix(1'b1, x, 9, 1'b1, 1'b1);
        flush();

        pix(1'b0, 645, 100, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) pix(1'b0, 656 + i, 100, 1'b0, 1'b1);
        pix(1'b0, 750, 100, 1'b1, 1'b1);
        flush();

        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);
        flush();
        vs_pulses(29);
        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);
        flush();
        vs_pulses(1);
        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);
        flush();
        vs_pulses(30);
        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);
        flush();

        cursorEn = 1'b1;
        flush();
        for (int x = 78; x < 90; x++) pix(1'b1, x, 32, 1'b1, 1'b1);
        for (int x = 78; x < 90; x++) pix(1'b1, x, 39, 1'b1, 1'b1);
        flush();
        vs_pulses(30);
        for (int x = 78; x < 90; x++) pix(1'b1, x, 35, 1'b1, 1'b1);
        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);

        do_reset();
        for (int x = 40; x < 48; x++) pix(1'b1, x, 26, 1'b1, 1'b1);
        flush();

        for (int blk = 0; blk < 40; blk++) begin
            cursorCol = 7'($urandom_range(0, 79));
            cursorRow = 6'($urandom_range(0, 59));
            cursorEn  = 1'($urandom);
            flush();
            for (int i = 0; i < 60; i++) begin
                int   h, v;
                logic br;
                h  = int'($urandom_range(0, 799));
                v  = int'($urandom_range(0, 524));
                br = (h < 640) && (v < 480) && ($urandom_range(0, 3) != 0);
                pix(br, h, v, $urandom_range(0, 5) != 0, $urandom_range(0, 9) != 0);
            end
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
